// File: rtl/pdetect_frame_sync.sv
// Byte-stream frame synchroniser: hunt/verify/lock on a programmable 32-bit sync word, payload delivery.
// Optional PDETECT_SYNC_STATS_EN adds o_frame_cnt / o_slip_cnt statistics outputs.
module pdetect_frame_sync #(
   parameter int unsigned FRAME_LEN     = 64,
   parameter int unsigned VERIFY_COUNT  = 2,
   parameter int unsigned LOSS_COUNT    = 3,
   parameter logic [31:0] RESET_PATTERN = 32'h0A0B0C0D
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   input  logic        i_cfg_load,
   input  logic [31:0] i_cfg_pattern,
   output logic        o_valid,
   output logic [7:0]  o_data,
   output logic        o_sof,
   output logic        o_eof,
   output logic        o_locked,
   output logic [1:0]  o_state
`ifdef PDETECT_SYNC_STATS_EN
   ,
   output logic [15:0] o_frame_cnt,
   output logic [7:0]  o_slip_cnt
`endif
);

   localparam int unsigned CW = $clog2(FRAME_LEN);
   localparam int unsigned HW = $clog2(VERIFY_COUNT + 1);
   localparam int unsigned MW = $clog2(LOSS_COUNT + 1);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t          state, state_d;
   logic [31:0]     pattern;
   logic [23:0]     window;
   logic [1:0]      fill;
   logic [CW-1:0]   cnt, cnt_d;
   logic [HW-1:0]   hits, hits_d;
   logic [MW-1:0]   misses, misses_d;
   logic            match;
   logic            ckpt;
   logic            pay;
   logic            pay_sof;
   logic            pay_eof;

   assign match   = i_valid && (fill == 2'd3) && ({window, i_data} == pattern);
   assign ckpt    = (cnt == CW'(FRAME_LEN - 1));
   assign pay     = i_valid && (state == LOCKED) && (cnt <= CW'(FRAME_LEN - 5));
   assign pay_sof = pay && (cnt == '0);
   assign pay_eof = pay && (cnt == CW'(FRAME_LEN - 5));
   assign o_state = state;

   // State register; a pattern reload restarts the hunt
   always_ff @(posedge i_clk) begin
      if (i_rst || i_cfg_load) state <= HUNT;
      else                     state <= state_d;
   end

   // Next-state and frame-position counters, evaluated on each accepted byte
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      hits_d   = hits;
      misses_d = misses;
      if (i_valid) begin
         cnt_d = ckpt ? '0 : cnt + CW'(1);
         unique case (state)
            HUNT: begin
               if (match) begin
                  state_d = VERIFY;
                  hits_d  = '0;
                  cnt_d   = '0;
               end
            end
            VERIFY: begin
               if (ckpt) begin
                  if (match) begin
                     hits_d = hits + HW'(1);
                     if (32'(hits) + 32'd1 >= VERIFY_COUNT) begin
                        state_d  = LOCKED;
                        misses_d = '0;
                     end
                  end else begin
                     state_d = HUNT;
                  end
               end
            end
            LOCKED: begin
               if (ckpt) begin
                  if (match) begin
                     misses_d = '0;
                  end else if (32'(misses) + 32'd1 >= LOSS_COUNT) begin
                     state_d  = HUNT;
                     misses_d = '0;
                  end else begin
                     misses_d = misses + MW'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // Datapath: sync history, counters and registered payload outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pattern  <= RESET_PATTERN;
         window   <= '0;
         fill     <= '0;
         cnt      <= '0;
         hits     <= '0;
         misses   <= '0;
         o_valid  <= 1'b0;
         o_data   <= '0;
         o_sof    <= 1'b0;
         o_eof    <= 1'b0;
         o_locked <= 1'b0;
      end else if (i_cfg_load) begin
         pattern  <= i_cfg_pattern;
         fill     <= '0;
         cnt      <= '0;
         hits     <= '0;
         misses   <= '0;
         o_valid  <= 1'b0;
         o_sof    <= 1'b0;
         o_eof    <= 1'b0;
         o_locked <= 1'b0;
      end else begin
         cnt      <= cnt_d;
         hits     <= hits_d;
         misses   <= misses_d;
         o_valid  <= pay;
         o_sof    <= pay_sof;
         o_eof    <= pay_eof;
         o_locked <= (state_d == LOCKED);
         if (pay) o_data <= i_data;
         if (i_valid) begin
            window <= {window[15:0], i_data};
            if (fill != 2'd3) fill <= fill + 2'd1;
         end
      end
   end

`ifdef PDETECT_SYNC_STATS_EN
   logic loss_drop;

   // Only the loss path leaves LOCKED for HUNT; reloads are handled separately
   assign loss_drop = i_valid && (state == LOCKED) && (state_d == HUNT);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_cfg_load) begin
         o_frame_cnt <= '0;
         o_slip_cnt  <= '0;
      end else begin
         if (pay_eof && (o_frame_cnt != '1)) o_frame_cnt <= o_frame_cnt + 16'd1;
         if (loss_drop && (o_slip_cnt != '1)) o_slip_cnt <= o_slip_cnt + 8'd1;
      end
   end
`endif

endmodule
